// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer. The live count borrows downward on each tick while running.
// The display copy follows the count and freezes while lap is high. done/done_pulse mark 00:00.
module bcd_countdown_timer #(
  parameter int MIN_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       load,
  input  logic       clr,
  input  logic       lap,
  input  logic [3:0] preset_m1,
  input  logic [3:0] preset_m0,
  input  logic [3:0] preset_s1,
  input  logic [3:0] preset_s0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_m0,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_s0,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] M1_LIM = 4'(MIN_TENS_MAX);

  state_t     state, state_nxt;
  logic [3:0] m1_nxt, m0_nxt, s1_nxt, s0_nxt;
  logic       pulse_nxt;
  logic       count_zero, count_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign count_zero = ({m1, m0, s1, s0} == 16'h0000);
  assign count_one  = ({m1, m0, s1, s0} == 16'h0001);
  assign running    = (state == RUN);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    m1_nxt    = m1;
    m0_nxt    = m0;
    s1_nxt    = s1;
    s0_nxt    = s0;
    pulse_nxt = 1'b0;
    if (clr) begin
      {m1_nxt, m0_nxt, s1_nxt, s0_nxt} = 16'h0000;
      state_nxt = IDLE;
    end else if (load && state != RUN) begin
      m1_nxt    = clamp(preset_m1, M1_LIM);
      m0_nxt    = clamp(preset_m0, 4'd9);
      s1_nxt    = clamp(preset_s1, 4'd5);
      s0_nxt    = clamp(preset_s0, 4'd9);
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_pause && !count_zero) state_nxt = RUN;
        PAUSE: if (start_pause) state_nxt = RUN;
        RUN: begin
          if (tick && !count_zero) begin
            // Borrow ripples from seconds-ones up through minutes-tens.
            s0_nxt = (s0 == 4'd0) ? 4'd9 : s0 - 4'd1;
            if (s0 == 4'd0) begin
              s1_nxt = (s1 == 4'd0) ? 4'd5 : s1 - 4'd1;
              if (s1 == 4'd0) begin
                m0_nxt = (m0 == 4'd0) ? 4'd9 : m0 - 4'd1;
                if (m0 == 4'd0) m1_nxt = m1 - 4'd1;
              end
            end
          end
          if (tick && count_one) begin
            state_nxt = DONE;
            pulse_nxt = 1'b1;
          end else if (start_pause) begin
            state_nxt = PAUSE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      m1         <= 4'd0;
      m0         <= 4'd0;
      s1         <= 4'd0;
      s0         <= 4'd0;
      disp_m1    <= 4'd0;
      disp_m0    <= 4'd0;
      disp_s1    <= 4'd0;
      disp_s0    <= 4'd0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      m1         <= m1_nxt;
      m0         <= m0_nxt;
      s1         <= s1_nxt;
      s0         <= s0_nxt;
      done_pulse <= pulse_nxt;
      // clr wipes the display even while it is lap-frozen.
      if (clr || !lap) begin
        disp_m1 <= m1_nxt;
        disp_m0 <= m0_nxt;
        disp_s1 <= s1_nxt;
        disp_s0 <= s0_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed vector bench for bcd_countdown_timer: one table row per clock edge, plus an async-reset sequence.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, start_pause, load, clr, lap;
  logic [3:0] preset_m1, preset_m0, preset_s1, preset_s0;
  logic [3:0] m1, m0, s1, s0;
  logic [3:0] disp_m1, disp_m0, disp_s1, disp_s0;
  logic       running, done, done_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.MIN_TENS_MAX(9)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_pause(start_pause),
    .load(load), .clr(clr), .lap(lap),
    .preset_m1(preset_m1), .preset_m0(preset_m0), .preset_s1(preset_s1), .preset_s0(preset_s0),
    .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .disp_m1(disp_m1), .disp_m0(disp_m0), .disp_s1(disp_s1), .disp_s0(disp_s0),
    .running(running), .done(done), .done_pulse(done_pulse)
  );

  typedef struct {
    logic        tk, sp, ld, cl, lp;
    logic [15:0] pre;
    logic [15:0] cnt, dsp;
    logic        run, dn, dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic tk, input logic sp, input logic ld, input logic cl,
                              input logic lp, input logic [15:0] pre, input logic [15:0] cnt,
                              input logic [15:0] dsp, input logic run, input logic dn, input logic dp);
    vec_t v;
    v.tk = tk; v.sp = sp; v.ld = ld; v.cl = cl; v.lp = lp; v.pre = pre;
    v.cnt = cnt; v.dsp = dsp; v.run = run; v.dn = dn; v.dp = dp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " count"}, {16'h0, m1, m0, s1, s0}, 32'h0);
    chk({tag, " disp"}, {16'h0, disp_m1, disp_m0, disp_s1, disp_s0}, 32'h0);
    chk({tag, " run/done/pulse"}, {29'h0, running, done, done_pulse}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    {tick, start_pause, load, clr, lap} = 5'b0;
    {preset_m1, preset_m0, preset_s1, preset_s0} = 16'h0;

    //               tk sp ld cl lp  preset    count     disp     run dn dp
    // Start in IDLE at 00:00: start_pause is refused.
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    // 01:00 -> 00:59 -> 00:58.
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0100, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0059, 16'h0059, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0058, 16'h0058, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0058, 16'h0058, 1, 0, 0));
    // 00:02 down to DONE; done_pulse lasts one cycle; DONE is sticky until load.
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0002, 16'h0002, 16'h0002, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0005, 16'h0005, 16'h0005, 0, 0, 0));
    // 10:00 -> 09:59; load ignored in RUN; clamped load from PAUSE.
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1000, 16'h1000, 16'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h1000, 16'h1000, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0959, 16'h0959, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1234, 16'h0959, 16'h0959, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0959, 16'h0959, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'hF79A, 16'h9759, 16'h9759, 0, 0, 0));
    // Lap freeze at 05:30 while the count runs on; release re-syncs.
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0530, 16'h0530, 16'h0530, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0530, 16'h0530, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0529, 16'h0530, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0528, 16'h0530, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0527, 16'h0530, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0527, 16'h0527, 1, 0, 0));
    // clr clears the display even with lap held.
    vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    // IDLE + tick + start: no decrement; then DONE wins over start_pause at 00:01.
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0003, 16'h0003, 16'h0003, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0003, 16'h0003, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1));
    // 00:10: tick + start in RUN decrements and pauses; ticks ignored in PAUSE.
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0010, 16'h0010, 16'h0010, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0010, 16'h0010, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0009, 16'h0009, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0009, 16'h0009, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0009, 16'h0009, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0009, 16'h0009, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0008, 16'h0008, 1, 0, 0));

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      tick        = vecs[i].tk;
      start_pause = vecs[i].sp;
      load        = vecs[i].ld;
      clr         = vecs[i].cl;
      lap         = vecs[i].lp;
      {preset_m1, preset_m0, preset_s1, preset_s0} = vecs[i].pre;
      @(negedge clk);
      chk($sformatf("row%0d count", i), {16'h0, m1, m0, s1, s0}, {16'h0, vecs[i].cnt});
      chk($sformatf("row%0d disp", i), {16'h0, disp_m1, disp_m0, disp_s1, disp_s0}, {16'h0, vecs[i].dsp});
      chk($sformatf("row%0d run/done/pulse", i), {29'h0, running, done, done_pulse},
          {29'h0, vecs[i].run, vecs[i].dn, vecs[i].dp});
    end

    // Asynchronous reset mid-RUN: outputs clear before any clock edge.
    {tick, start_pause, load, clr, lap} = 5'b0;
    #2 reset = 1'b0;
    #1 chk_all_zero("async reset");
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    chk_all_zero("post reset idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Four-digit BCD MM:SS countdown timer. It is the down-counting counterpart of the stopwatch's BCD up-counter digit chain: it borrows downward instead of carrying upward. It uses the same one-second tick enable and the same lap/freeze display semantics. It drives the display scan logic and raises a done flag when the count reaches 00:00.

Parameters:
MIN_TENS_MAX, 9, upper clamp value for the minutes-tens digit on load (0-9)

Ports:
clk  input  1  global clock
reset  input  1  asynchronous, active-low reset
tick  input  1  one-cycle-wide 1 Hz enable pulse, synchronous to clk
start_pause  input  1  one-cycle pulse; starts, pauses or resumes the count
load  input  1  synchronous load of preset digits
clr  input  1  synchronous clear
lap  input  1  level; 1 = freeze display outputs
preset_m1  input  4  minutes tens preset (BCD)
preset_m0  input  4  minutes ones preset (BCD)
preset_s1  input  4  seconds tens preset (BCD)
preset_s0  input  4  seconds ones preset (BCD)
m1, m0, s1, s0  output  4 each  live count digits (registered)
disp_m1, disp_m0, disp_s1, disp_s0  output  4 each  display digits (registered, lap-frozen)
running  output  1  high while in RUN
done  output  1  high while in DONE
done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (reset=0, async): all count digits, all disp digits, running, done and done_pulse = 0; state = IDLE.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN); done = (state==DONE).
- Priority per edge: reset > clr > load > start_pause/tick.
- clr=1: count and disp digits <= 0 regardless of lap; state <= IDLE; done_pulse <= 0.
- load=1:
  - In IDLE, PAUSE or DONE: digits <= preset; state <= IDLE.
  - Clamping: m1 to MIN_TENS_MAX; m0 and s0 to 9; s1 to 5. Any preset value above its limit loads the limit.
  - In RUN: load is ignored.
- start_pause transitions:
  - IDLE: goes to RUN if count != 00:00; stays IDLE if count == 00:00.
  - RUN: goes to PAUSE.
  - PAUSE: goes to RUN.
  - DONE: ignored.
- Decrement: happens only when the current state is RUN and tick=1. Borrow chain:
  - s0: 0 -> 9 with borrow, else s0-1.
  - s1 (on borrow): 0 -> 5 with borrow, else s1-1.
  - m0 (on borrow): 0 -> 9 with borrow, else m0-1.
  - m1 (on borrow): m1-1.
- Terminal count: a tick in RUN with count 00:01 makes count 00:00 and state DONE on the same edge. done_pulse = 1 for exactly the following cycle. Count never decrements below 00:00.
- Simultaneous events:
  - RUN + tick + start_pause: decrement applies and state -> PAUSE.
  - IDLE/PAUSE + tick + start_pause: no decrement; state -> RUN (first decrement on a later tick).
  - RUN + tick + start_pause at 00:01: DONE wins; start_pause is ignored.
- Latency: live digits update on the clk edge that samples tick. Zero extra pipeline.
- Display: on each edge with lap=0, disp_* loads the same next-state value as the count, so disp == count on every cycle. With lap=1, disp_* holds while the count continues. Releasing lap re-syncs disp on the next edge.
- Reset asserted mid-RUN: everything clears immediately (async); state = IDLE.
- All digit registers always hold valid BCD. The s1 digit never exceeds 5.

Test Plan:
1. Reset low then high -> all outputs 0, running=0; start_pause in IDLE at 00:00 -> stays IDLE.
2. Load 01:00, start_pause, one tick -> 00:59; further tick -> 00:58; running=1.
3. Load 00:02, start, two ticks -> 00:00, done=1, done_pulse high exactly one cycle; further ticks and start_pause leave 00:00/DONE; load 00:05 -> IDLE, done=0.
4. Load 10:00, start, tick -> 09:59 (full borrow chain); load preset F:7:9:A -> count 9:7:5:9 (clamped).
5. Running at 05:30, lap=1, three ticks -> live 05:27, disp stays 05:30; lap=0 -> disp 05:27 on next edge.
6. Running at 00:10, tick and start_pause same cycle -> 00:09, state PAUSE; ticks ignored; start_pause -> RUN; reset pulse mid-run -> all 0, IDLE.
